// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for the branch redirect controller: branch types, FSM states, reset PC.
// Optional build macro used by the top: BRU_PERF_CNT_EN (performance counters).
package branch_redirect_ctrl_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EVAL     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Issue, redirect and writeback handshakes of the branch redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      branch_type;
  logic            is_jal;
  logic            is_jalr;
  logic            pred_taken;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] link_data;
  logic            misalign;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_taken;
  logic [31:0]     perf_mispred;

  modport slave (
    input  in_valid, pc, imm, rs1, rs2, branch_type, is_jal, is_jalr, pred_taken,
           redirect_ready, out_ready,
    output in_ready, redirect_valid, redirect_pc, flush, out_valid, link_data, misalign,
           perf_branches, perf_taken, perf_mispred
  );

  modport master (
    output in_valid, pc, imm, rs1, rs2, branch_type, is_jal, is_jalr, pred_taken,
           redirect_ready, out_ready,
    input  in_ready, redirect_valid, redirect_pc, flush, out_valid, link_data, misalign,
           perf_branches, perf_taken, perf_mispred
  );
endinterface

// File: rtl/branch_redirect_ctrl_branch_cmp.sv
// Combinational branch condition evaluator: operands and branch type to taken.
module branch_cmp
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      branch_type,
  output logic            taken
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves taken unassigned (no latch).
    taken = 1'b0;
    case (branch_type)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 <  rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump resolution FSM: evaluates one instruction, redirects IFU on mispredict, returns link to WBU.
// Build macro BRU_PERF_CNT_EN adds branch/taken/mispredict counters; otherwise perf ports read 0.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                    clock,
  input logic                    reset,
  branch_redirect_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      bt;
    logic            jal;
    logic            jalr;
    logic            pred;
  } instr_t;

  logic [1:0]      state_q, state_d;
  instr_t          instr_q, instr_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            misalign_q, misalign_d;
  logic            flush_q, flush_d;

  logic            cmp_taken;
  logic            taken;
  logic            mispred;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1         (instr_q.rs1),
    .rs2         (instr_q.rs2),
    .branch_type (instr_q.bt),
    .taken       (cmp_taken)
  );

  // Resolution datapath, meaningful only while in EVAL.
  always_comb begin
    taken   = instr_q.jal | instr_q.jalr | cmp_taken;
    target  = instr_q.jalr ? ((instr_q.rs1 + instr_q.imm) & {{(XLEN-1){1'b1}}, 1'b0})
                           : (instr_q.pc + instr_q.imm);
    seq_pc  = instr_q.pc + XLEN'(4);
    next_pc = taken ? target : seq_pc;
    mispred = (taken != instr_q.pred) | instr_q.jalr;
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    redirect_pc_d = redirect_pc_q;
    link_d        = link_q;
    misalign_d    = misalign_q;
    flush_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          instr_d = '{pc: bus.pc, imm: bus.imm, rs1: bus.rs1, rs2: bus.rs2,
                      bt: bus.branch_type, jal: bus.is_jal, jalr: bus.is_jalr,
                      pred: bus.pred_taken};
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        link_d     = seq_pc;
        misalign_d = taken & next_pc[1];
        if (mispred) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = next_pc;
          flush_d       = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d       = ST_DONE;
          redirect_pc_d = RESET_PC;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= RESET_PC;
      link_q        <= '0;
      misalign_q    <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      link_q        <= link_d;
      misalign_q    <= misalign_d;
      flush_q       <= flush_d;
    end
  end

  // NOTE: the captured instruction is left unreset; it is only read after a fresh capture in IDLE.
  always_ff @(posedge clock) begin
    instr_q <= instr_d;
  end

  assign bus.in_ready       = (state_q == ST_IDLE);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.out_valid      = (state_q == ST_DONE);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.link_data      = link_q;
  assign bus.misalign       = misalign_q & (state_q == ST_DONE);

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_tk_q, perf_tk_d;
  logic [31:0] perf_mp_q, perf_mp_d;

  always_comb begin
    perf_br_d = perf_br_q;
    perf_tk_d = perf_tk_q;
    perf_mp_d = perf_mp_q;
    if (state_q == ST_EVAL) begin
      perf_br_d = perf_br_q + 32'd1;
      if (taken)   perf_tk_d = perf_tk_q + 32'd1;
      if (mispred) perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_tk_q <= perf_tk_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign bus.perf_branches = perf_br_q;
  assign bus.perf_taken    = perf_tk_q;
  assign bus.perf_mispred  = perf_mp_q;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_taken    = '0;
  assign bus.perf_mispred  = '0;
`endif

endmodule
